// File: rtl/reflex_game_ctrl_if.sv
// Pin-side bundle of the reaction game controller: raw buttons/switches in,
// LED drive, BCD score, miss count and event pulses out.
interface reflex_game_ctrl_if #(
    parameter int LED_NUM = 8
);
    logic               start;
    logic [LED_NUM-1:0] sw;
    logic [LED_NUM-1:0] led;
    logic [15:0]        score_bcd;
    logic [3:0]         miss_cnt;
    logic               hit;
    logic               fail;
    logic               game_over;

    modport master (
        output start, sw,
        input  led, score_bcd, miss_cnt, hit, fail, game_over
    );

    modport slave (
        input  start, sw,
        output led, score_bcd, miss_cnt, hit, fail, game_over
    );
endinterface

// File: rtl/reflex_game_ctrl.sv
// Reaction game core: picks a random LED per round, times the matching switch,
// keeps a saturating BCD score and a miss count, and ends after MAX_MISS misses.
//
// state | meaning
// IDLE  | waiting for the first start press, LEDs dark
// ARM   | one cycle: choose next channel, clear round timer
// SHOW  | one LED lit, waiting for a press or timeout
// HIT   | one cycle: correct press, score advances
// MISS  | one cycle: wrong press or timeout, miss count advances
// OVER  | all LEDs lit, score frozen until start press
module reflex_game_ctrl #(
    parameter int          LED_NUM     = 8,
    parameter int          TICK_DIV    = 25000000,
    parameter int          ROUND_TICKS = 6,
    parameter int          MAX_MISS    = 3,
    parameter int          DEB_CYC     = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic              clk,
    input logic              clr,
    reflex_game_ctrl_if.slave bus
);

    localparam int N_IN   = LED_NUM + 1;
    localparam int DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int IDX_W  = $clog2(LED_NUM);
    localparam int CYC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_W = $clog2(ROUND_TICKS + 1);
    localparam int LVL_W  = $clog2(ROUND_TICKS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        SHOW = 3'd2,
        HIT  = 3'd3,
        MISS = 3'd4,
        OVER = 3'd5
    } state_t;

    state_t state, next_state;

    logic [N_IN-1:0]    raw, sync1, sync2, acc, acc_d, press;
    logic [DEB_W-1:0]   deb_cnt [N_IN];
    logic [LED_NUM-1:0] sw_press;
    logic               start_press;

    logic [15:0]        lfsr;
    logic [IDX_W-1:0]   idx_raw, idx_sel, cur;
    logic [LED_NUM-1:0] cur_mask;

    logic [CYC_W-1:0]   cyc_cnt;
    logic [TICK_W-1:0]  tick_cnt, limit;
    logic [LVL_W-1:0]   level;
    logic               cyc_wrap, timeout;

    logic [15:0]        score_q;
    logic [3:0]         miss_q;
    logic               hit_q, fail_q, hit_set, fail_set;
    logic [LED_NUM-1:0] led_c;

    // Input conditioning: start rides along as the top channel.
    assign raw = {bus.start, bus.sw};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= '0;
            sync2 <= '0;
            acc_d <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            acc_d <= acc;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc <= '0;
            for (int i = 0; i < N_IN; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == acc[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                    acc[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press       = acc & ~acc_d;
    assign sw_press    = press[LED_NUM-1:0];
    assign start_press = press[LED_NUM];

    // Galois LFSR, x^16+x^14+x^13+x^11, free-running in every state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            lfsr <= LFSR_SEED;
        else if (lfsr[0])
            lfsr <= (lfsr >> 1) ^ 16'hB400;
        else
            lfsr <= lfsr >> 1;
    end

    // Never light the same channel twice in a row.
    always_comb begin
        idx_raw = IDX_W'(32'(lfsr[7:0]) % LED_NUM);
        idx_sel = idx_raw;
        if (idx_raw == cur)
            idx_sel = (idx_raw == IDX_W'(LED_NUM - 1)) ? '0 : idx_raw + 1'b1;
    end

    assign cur_mask = {{(LED_NUM-1){1'b0}}, 1'b1} << cur;

    always_comb begin
        int lim_int;
        lim_int = ROUND_TICKS - int'(level);
        if (lim_int < 1)
            lim_int = 1;
        limit = TICK_W'(lim_int);
    end

    assign cyc_wrap = (cyc_cnt == CYC_W'(TICK_DIV - 1));
    assign timeout  = cyc_wrap && (tick_cnt == limit - 1'b1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cyc_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state == ARM) begin
            cyc_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state == SHOW) begin
            if (cyc_wrap) begin
                cyc_cnt  <= '0;
                tick_cnt <= tick_cnt + 1'b1;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        led_c      = '0;
        hit_set    = 1'b0;
        fail_set   = 1'b0;
        case (state)
            IDLE: if (start_press) next_state = ARM;
            ARM:  next_state = SHOW;
            SHOW: begin
                led_c = cur_mask;
                // A press always beats a coincident timeout.
                if (|sw_press) begin
                    if (sw_press == cur_mask) begin
                        next_state = HIT;
                        hit_set    = 1'b1;
                    end else begin
                        next_state = MISS;
                        fail_set   = 1'b1;
                    end
                end else if (timeout) begin
                    next_state = MISS;
                    fail_set   = 1'b1;
                end
            end
            HIT:  next_state = ARM;
            MISS: next_state = (miss_q + 1'b1 == 4'(MAX_MISS)) ? OVER : ARM;
            OVER: begin
                led_c = '1;
                if (start_press) next_state = ARM;
            end
            default: next_state = IDLE;
        endcase
    end

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cur     <= '0;
            hit_q   <= 1'b0;
            fail_q  <= 1'b0;
            score_q <= '0;
            miss_q  <= '0;
            level   <= '0;
        end else begin
            hit_q  <= hit_set;
            fail_q <= fail_set;
            if (state == ARM)
                cur <= idx_sel;
            if (state == HIT && score_q != 16'h9999) begin
                score_q <= bcd_inc(score_q);
                if (score_q[3:0] == 4'd9 && level < LVL_W'(ROUND_TICKS - 1))
                    level <= level + 1'b1;
            end
            if (state == MISS)
                miss_q <= miss_q + 1'b1;
            if (state == OVER && start_press) begin
                score_q <= '0;
                miss_q  <= '0;
                level   <= '0;
            end
        end
    end

    assign bus.led       = led_c;
    assign bus.score_bcd = score_q;
    assign bus.miss_cnt  = miss_q;
    assign bus.hit       = hit_q;
    assign bus.fail      = fail_q;
    assign bus.game_over = (state == OVER);

endmodule

// File: tb/tb_reflex_game_ctrl.sv
// Directed bench for reflex_game_ctrl with a fast tick and short debounce;
// all expected values are worked out by hand from the cycle timing.
module tb_reflex_game_ctrl;

    logic       clk;
    logic       clr;
    int         vectors;
    int         miscompares;
    logic [7:0] prev_led;
    logic [7:0] cur_led;

    reflex_game_ctrl_if #(.LED_NUM(8)) bus ();

    reflex_game_ctrl #(
        .LED_NUM    (8),
        .TICK_DIV   (4),
        .ROUND_TICKS(4),
        .MAX_MISS   (3),
        .DEB_CYC    (2),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led"},   32'(bus.led), 32'h0);
        check({tag, "_score"}, 32'(bus.score_bcd), 32'h0);
        check({tag, "_miss"},  32'(bus.miss_cnt), 32'h0);
        check({tag, "_hit"},   32'(bus.hit), 32'h0);
        check({tag, "_fail"},  32'(bus.fail), 32'h0);
        check({tag, "_over"},  32'(bus.game_over), 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr         = 1'b0;
        bus.start   = 1'b0;
        bus.sw      = '0;
        step(3);
        check_all_zero("reset");
        clr = 1'b1;
        step(2);

        // Start press: ARM after 5 edges, SHOW after 6.
        bus.start = 1'b1;
        step(5);
        check("arm_led_dark", 32'(bus.led), 32'h0);
        step(1);
        check("show_onehot", 32'($countones(bus.led)), 32'd1);
        check("show_score", 32'(bus.score_bcd), 32'h0);
        check("show_miss", 32'(bus.miss_cnt), 32'h0);
        check("show_no_hit", 32'(bus.hit), 32'h0);
        check("show_no_fail", 32'(bus.fail), 32'h0);
        bus.start = 1'b0;

        // Correct press: hit exactly 5 cycles after the raw edge.
        prev_led = bus.led;
        bus.sw   = bus.led;
        step(4);
        check("hit_not_early", 32'(bus.hit), 32'h0);
        step(1);
        check("hit_at_5", 32'(bus.hit), 32'h1);
        check("hit_led_dark", 32'(bus.led), 32'h0);
        step(1);
        check("hit_one_cycle", 32'(bus.hit), 32'h0);
        check("score_one", 32'(bus.score_bcd), 32'h0001);
        bus.sw = '0;
        step(1);
        check("round2_onehot", 32'($countones(bus.led)), 32'd1);
        check("round2_new_cur", 32'(bus.led != prev_led), 32'h1);

        // Timeout after 16 SHOW cycles; a 1-cycle glitch on the lit switch is ignored.
        step(2);
        cur_led = bus.led;
        bus.sw  = cur_led;
        step(1);
        bus.sw = '0;
        step(12);
        check("timeout_not_early", 32'(bus.fail), 32'h0);
        check("glitch_still_show", 32'(bus.led), 32'(cur_led));
        step(1);
        check("timeout_fail", 32'(bus.fail), 32'h1);
        check("timeout_no_hit", 32'(bus.hit), 32'h0);
        step(1);
        check("miss_one", 32'(bus.miss_cnt), 32'd1);
        step(1);

        // Correct and wrong switch together is a miss.
        cur_led = bus.led;
        bus.sw  = cur_led | {cur_led[6:0], cur_led[7]};
        step(5);
        check("dual_fail", 32'(bus.fail), 32'h1);
        check("dual_no_hit", 32'(bus.hit), 32'h0);
        step(1);
        check("miss_two", 32'(bus.miss_cnt), 32'd2);
        bus.sw = '0;
        step(1);
        check("round4_onehot", 32'($countones(bus.led)), 32'd1);

        // Third miss ends the game.
        step(16);
        check("third_fail", 32'(bus.fail), 32'h1);
        step(1);
        check("over_flag", 32'(bus.game_over), 32'h1);
        check("over_leds", 32'(bus.led), 32'hFF);
        check("over_miss", 32'(bus.miss_cnt), 32'd3);
        check("over_score_held", 32'(bus.score_bcd), 32'h0001);
        step(3);
        check("over_holds", 32'(bus.game_over), 32'h1);

        // Restart from OVER clears score and misses.
        bus.start = 1'b1;
        step(5);
        check("restart_score", 32'(bus.score_bcd), 32'h0);
        check("restart_miss", 32'(bus.miss_cnt), 32'h0);
        check("restart_over", 32'(bus.game_over), 32'h0);
        step(1);
        check("restart_onehot", 32'($countones(bus.led)), 32'd1);
        bus.start = 1'b0;

        // Ten hits in a row wrap units and raise the level.
        for (int i = 0; i < 10; i++) begin
            bus.sw = bus.led;
            step(5);
            check("run_hit", 32'(bus.hit), 32'h1);
            step(1);
            bus.sw = '0;
            step(1);
        end
        check("score_ten", 32'(bus.score_bcd), 32'h0010);

        // Level 1 allows only 3 ticks.
        step(11);
        check("lvl1_not_early", 32'(bus.fail), 32'h0);
        step(1);
        check("lvl1_fail", 32'(bus.fail), 32'h1);
        step(1);
        check("lvl1_miss", 32'(bus.miss_cnt), 32'd1);
        step(1);

        // Score saturates at 9999.
        force dut.score_q = 16'h9998;
        step(1);
        release dut.score_q;
        bus.sw = bus.led;
        step(5);
        check("sat_hit_a", 32'(bus.hit), 32'h1);
        step(1);
        check("sat_score_a", 32'(bus.score_bcd), 32'h9999);
        bus.sw = '0;
        step(1);
        bus.sw = bus.led;
        step(5);
        check("sat_hit_b", 32'(bus.hit), 32'h1);
        step(1);
        check("sat_score_b", 32'(bus.score_bcd), 32'h9999);
        bus.sw = '0;
        step(1);
        check("sat_show", 32'($countones(bus.led)), 32'd1);

        // Asynchronous clear in the middle of a round.
        #3 clr = 1'b0;
        #1;
        check_all_zero("async_clr");
        @(posedge clk);
        #1 clr = 1'b1;
        step(3);
        check("idle_led", 32'(bus.led), 32'h0);
        check("idle_over", 32'(bus.game_over), 32'h0);
        bus.start = 1'b1;
        step(5);
        check("idle_arm_dark", 32'(bus.led), 32'h0);
        step(1);
        check("idle_restart_onehot", 32'($countones(bus.led)), 32'd1);
        bus.start = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reflex_game_ctrl.md
Name: reflex_game_ctrl

Overview:
Parametrised core controller for the LED/switch reaction game. Each round it lights exactly one of LED_NUM LEDs, chosen pseudo-randomly, and waits a bounded time for the matching switch. It scores hits in BCD for the 4-digit seven-segment path, counts misses, shortens the allowed reaction time as the score grows, and ends the game after MAX_MISS misses. It sits between the clock divider (which supplies no timing here; the block has its own tick counter) and the display/LED pins.

Parameters:
LED_NUM, 8, number of LED/switch channels (2..16)
TICK_DIV, 25000000, clk cycles per round tick
ROUND_TICKS, 6, ticks allowed per round at level 0 (>=2)
MAX_MISS, 3, misses that end the game (1..15)
DEB_CYC, 16, stable cycles required to accept a switch change
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-low
start  in  1  raw start button, level
sw  in  LED_NUM  raw switch inputs
led  out  LED_NUM  LED drive, one-hot in SHOW
score_bcd  out  16  4-digit BCD score, [3:0]=units
miss_cnt  out  4  misses this game
hit  out  1  one-cycle pulse on a correct hit
fail  out  1  one-cycle pulse on a miss
game_over  out  1  high in OVER

Behaviour:
- Reset (clr=0, async): state IDLE; led=0, score_bcd=0, miss_cnt=0, hit=0, fail=0, game_over=0; LFSR=LFSR_SEED; level=0; tick/cycle counters=0; debouncers' accepted values=0.
- Input path, per channel of sw and for start: 2-FF synchroniser, then debounce. The accepted value changes after DEB_CYC consecutive cycles of a differing synchronised value. A rising edge of the accepted value gives a one-cycle press pulse. Raw change to press pulse = DEB_CYC+2 cycles. The FSM acts on the press pulse in the same cycle; hit/fail are registered and assert one cycle later (DEB_CYC+3 in total).
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every cycle in all states.
- idx = lfsr[7:0] mod LED_NUM. If idx equals the previous round's channel, use (idx+1) mod LED_NUM.
- limit = max(1, ROUND_TICKS - level). level increments each time score units wrap 9->0, saturating at ROUND_TICKS-1.
- FSM:
  - IDLE: led=0. start press -> ARM.
  - ARM (1 cycle): latch idx into cur; clear tick/cycle counters -> SHOW.
  - SHOW: led = one-hot(cur).
    - Press on channel cur only -> HIT.
    - Press on any other channel, including together with cur in the same cycle -> MISS.
    - Tick count reaching limit with no press -> MISS.
    - Press and timeout in the same cycle: the press decides the outcome.
  - HIT (1 cycle): led=0; hit=1 next cycle; score_bcd += 1 in BCD, saturating at 9999 (no wrap, level unchanged at saturation) -> ARM.
  - MISS (1 cycle): led=0; fail=1 next cycle; miss_cnt += 1. If the new miss_cnt equals MAX_MISS -> OVER, else -> ARM.
  - OVER: led all ones; game_over=1; score and misses held. start press clears score, miss_cnt and level -> ARM.
- Presses outside SHOW are ignored (no hit/fail), except start in IDLE/OVER. A start press during play is ignored.
- Tick counter: cycle counter 0..TICK_DIV-1, runs only in SHOW; tick count increments on wrap.
- clr asserted mid-round: immediate return to reset values; no pending pulses survive.

Test Plan:
Bench parameters: LED_NUM=8, TICK_DIV=4, ROUND_TICKS=4, MAX_MISS=3, DEB_CYC=2.
- Reset then start press -> ARM, then SHOW with exactly one led bit set; score_bcd=0, miss_cnt=0, no pulses.
- In SHOW, raise sw[cur] and hold -> hit pulse exactly 5 cycles after the raw edge; score_bcd=16'h0001; new round's cur differs from the previous cur.
- In SHOW, no press -> fail after 4 ticks (16 cycles of SHOW, plus 1); miss_cnt=1; a glitch of 1 cycle on sw[cur] during the wait is rejected.
- Raise sw[cur] and a wrong switch on the same cycle -> fail, not hit. Three misses total -> game_over=1, led=8'hFF. Start press -> score/miss cleared, play resumes.
- Force 10 consecutive hits -> score_bcd=16'h0010 and the next timeout occurs after 3 ticks. Preload near saturation -> score holds at 16'h9999.
- Assert clr during SHOW -> all outputs 0 in the same cycle (async); state IDLE after release.
